// File: rtl/prompt_sequencer.sv
// prompt_sequencer: stores a pseudo-random sequence of prompt codes (one code
// appended per extend pulse) and plays it back as timed ON/OFF prompt phases.
// Optional build macro PROMPT_SPEEDUP_EN: when defined, the phase duration
// shrinks by a power of two every four stored entries (down to 1/8).
module prompt_sequencer #(
    parameter int         MAX_LEN   = 16,
    parameter int         TICK_DIV  = 25000000,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       extend,
    input  logic                       play,
    input  logic                       clear,
    output logic [2:0]                 prompt,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(MAX_LEN):0]   length,
    output logic                       full
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TICK_DIV) + 1;
    localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF, ST_DONE} state_t;

    state_t        state_r, state_n;
    logic [7:0]    lfsr_r;
    logic [1:0]    mem_r [MAX_LEN];
    logic [LW-1:0] length_r, length_n, len_eff_s;
    logic [AW-1:0] index_r, index_n;
    logic [CW-1:0] count_r, count_n, load_run_s, load_start_s;
    logic [2:0]    prompt_r, prompt_n;
    logic          busy_r, busy_n, done_r, done_n, full_r, full_n;
    logic          append_s, start_s, last_s;
    logic [1:0]    code_s;

    // Galois LFSR step, right shift with feedback mask 8'hB8; never reaches zero
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return (cur >> 1) ^ (cur[0] ? 8'hB8 : 8'h00);
    endfunction

`ifdef PROMPT_SPEEDUP_EN
    localparam int DUR0 = TICK_DIV;
    localparam int DUR1 = ((TICK_DIV >> 1) < 1) ? 1 : (TICK_DIV >> 1);
    localparam int DUR2 = ((TICK_DIV >> 2) < 1) ? 1 : (TICK_DIV >> 2);
    localparam int DUR3 = ((TICK_DIV >> 3) < 1) ? 1 : (TICK_DIV >> 3);

    logic [1:0]    shift_r, shift_n, shift_new_s;
    logic [LW-1:0] quarter_s;

    // Counter reload value for a given speed step (one of four constants)
    function automatic logic [CW-1:0] phase_load(input logic [1:0] s);
        case (s)
            2'd0:    return CW'(DUR0 - 1);
            2'd1:    return CW'(DUR1 - 1);
            2'd2:    return CW'(DUR2 - 1);
            2'd3:    return CW'(DUR3 - 1);
            default: return CW'(DUR0 - 1);
        endcase
    endfunction

    // Speed step from the length playback will cover; latched when play is accepted
    always_comb begin
        quarter_s   = len_eff_s >> 2;
        shift_new_s = (quarter_s > LW'(3)) ? 2'd3 : quarter_s[1:0];
        if (start_s) begin
            shift_n = shift_new_s;
        end else begin
            shift_n = shift_r;
        end
        load_start_s = phase_load(shift_new_s);
        load_run_s   = phase_load(shift_r);
    end

    // Held speed step for the whole playback
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_r <= 2'd0;
        end else begin
            shift_r <= shift_n;
        end
    end
`else
    // Fixed phase duration
    always_comb begin
        load_start_s = CW'(TICK_DIV - 1);
        load_run_s   = CW'(TICK_DIV - 1);
    end
`endif

    // Request qualification: clear overrides extend and play
    always_comb begin
        append_s  = (state_r == ST_IDLE) && extend && !full_r && !clear;
        start_s   = (state_r == ST_IDLE) && play && !clear;
        len_eff_s = length_r + (append_s ? LW'(1) : LW'(0));
        last_s    = ({1'b0, index_r} == (length_r - LW'(1)));
    end

    // Next-state logic for playback FSM, phase counter, length and outputs
    always_comb begin
        state_n = state_r;
        index_n = index_r;
        count_n = count_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    if (len_eff_s != LW'(0)) begin
                        state_n = ST_ON;
                        index_n = AW'(0);
                        count_n = load_start_s;
                    end else begin
                        state_n = ST_DONE;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ON: begin
                if (count_r == CW'(0)) begin
                    state_n = ST_OFF;
                    count_n = load_run_s;
                end else begin
                    count_n = count_r - CW'(1);
                end
            end
            ST_OFF: begin
                if (count_r == CW'(0)) begin
                    if (last_s) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_ON;
                        index_n = index_r + AW'(1);
                        count_n = load_run_s;
                    end
                end else begin
                    count_n = count_r - CW'(1);
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (clear) begin
            state_n  = ST_IDLE;
            index_n  = AW'(0);
            count_n  = CW'(0);
            length_n = LW'(0);
        end else begin
            length_n = len_eff_s;
        end

        // The entry written at this edge is forwarded so extend+play on an
        // empty sequence shows the new code immediately.
        if (append_s && (length_r[AW-1:0] == index_n)) begin
            code_s = lfsr_r[1:0];
        end else begin
            code_s = mem_r[index_n];
        end

        prompt_n = (state_n == ST_ON) ? ({1'b0, code_s} + 3'd1) : 3'd0;
        busy_n   = (state_n == ST_ON) || (state_n == ST_OFF);
        done_n   = (state_n == ST_DONE);
        full_n   = (length_n == MAX_LEN_L);
    end

    // State, counters, LFSR and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            lfsr_r   <= LFSR_SEED;
            length_r <= LW'(0);
            index_r  <= AW'(0);
            count_r  <= CW'(0);
            prompt_r <= 3'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            full_r   <= 1'b0;
        end else begin
            state_r  <= state_n;
            lfsr_r   <= lfsr_next(lfsr_r);
            length_r <= length_n;
            index_r  <= index_n;
            count_r  <= count_n;
            prompt_r <= prompt_n;
            busy_r   <= busy_n;
            done_r   <= done_n;
            full_r   <= full_n;
        end
    end

    // Sequence storage: append at address length using the pre-advance LFSR
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                mem_r[i] <= 2'd0;
            end
        end else if (append_s) begin
            mem_r[length_r[AW-1:0]] <= lfsr_r[1:0];
        end
    end

    assign prompt = prompt_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign length = length_r;
    assign full   = full_r;

endmodule

// File: tb/tb_prompt_sequencer.sv
// Self-checking bench for prompt_sequencer (MAX_LEN=16, TICK_DIV=4).
module tb_prompt_sequencer;
    localparam int ML = 16;
    localparam int TD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       extend = 1'b0, play = 1'b0, clear = 1'b0;
    logic [2:0] prompt;
    logic       busy, done, full;
    logic [4:0] length;

    prompt_sequencer #(.MAX_LEN(ML), .TICK_DIV(TD), .LFSR_SEED(8'hA5)) dut (
        .clock(clock), .reset(reset), .extend(extend), .play(play), .clear(clear),
        .prompt(prompt), .busy(busy), .done(done), .length(length), .full(full)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference: LFSR value sequence and the list of stored codes
    logic [7:0] m_lfsr;
    logic [1:0] q[$];

    always @(posedge clock or negedge reset) begin
        if (!reset) m_lfsr <= 8'hA5;
        else        m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
    end

    typedef struct {
        bit e;
        bit c;
        int exp_len;
        bit exp_full;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic int dur(input int len);
        int d;
`ifdef PROMPT_SPEEDUP_EN
        int s;
        s = len / 4;
        if (s > 3) s = 3;
        d = TD / (1 << s);
        if (d < 1) d = 1;
`else
        d = TD;
`endif
        return d;
    endfunction

    task automatic cyc(input logic e, input logic p, input logic c);
        extend = e; play = p; clear = c;
        @(posedge clock);
        #1;
        extend = 1'b0; play = 1'b0; clear = 1'b0;
    endtask

    task automatic do_ext();
        if (q.size() < ML) q.push_back(m_lfsr[1:0]);
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        q.delete();
        cyc(1'b0, 1'b0, 1'b1);
    endtask

    // Play the stored sequence and compare every cycle to the expected waveform
    task automatic run_play(input bit with_ext, input int clr_at, input bit inject,
                            output int pulses, output int to_done, output logic [2:0] first_p);
        int d, n, total;
        logic [2:0] ep;
        logic eb, ed, prev_nz;
        if (with_ext && q.size() < ML) q.push_back(m_lfsr[1:0]);
        n = q.size();
        d = dur(n);
        total = 2 * n * d;
        pulses = 0; to_done = -1; prev_nz = 1'b0; first_p = 3'd0;
        cyc(with_ext, 1'b1, 1'b0);
        for (int k = 0; k <= total + 1; k++) begin
            if (k < total) begin
                ep = (((k / d) % 2) == 0) ? ({1'b0, q[k / (2 * d)]} + 3'd1) : 3'd0;
                eb = 1'b1; ed = 1'b0;
            end else if (k == total) begin
                ep = 3'd0; eb = 1'b0; ed = 1'b1;
            end else begin
                ep = 3'd0; eb = 1'b0; ed = 1'b0;
            end
            if (k == 0) first_p = prompt;
            chk("prompt", prompt, ep);
            chk("busy", busy, eb);
            chk("done", done, ed);
            if (prompt != 3'd0 && !prev_nz) pulses++;
            prev_nz = (prompt != 3'd0);
            if (done === 1'b1 && to_done < 0) to_done = k;
            if (k == clr_at) begin
                do_clear();
                chk("clr_prompt", prompt, 0);
                chk("clr_busy", busy, 0);
                chk("clr_length", length, 0);
                chk("clr_done", done, 0);
                for (int j = 0; j < 2 * d; j++) begin
                    cyc(1'b0, 1'b0, 1'b0);
                    chk("clr_no_done", done, 0);
                end
                return;
            end
            if (k < total + 1) cyc(inject ? 1'($urandom % 2) : 1'b0, inject ? 1'($urandom % 2) : 1'b0, 1'b0);
        end
        chk("len_after_play", length, q.size());
        chk("full_after_play", full, (q.size() == ML));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses, to_done;
        logic [2:0] fp;

        #2 reset = 1'b0;
        #10;
        chk("rst_prompt", prompt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_length", length, 0);
        chk("rst_full", full, 0);
        @(negedge clock);
        reset = 1'b1;

        // First active cycle extend: LFSR 8'hA5 stores code 1, shown as prompt 2
        do_ext();
        chk("len_first", length, 1);
        run_play(1'b0, -1, 1'b0, pulses, to_done, fp);
        chk("first_prompt", fp, 2);
        chk("first_done_at", to_done, 8);
        chk("first_pulses", pulses, 1);

        // Play with an empty sequence: done in the next cycle, no prompt
        do_clear();
        run_play(1'b0, -1, 1'b0, pulses, to_done, fp);
        chk("empty_done_at", to_done, 0);
        chk("empty_pulses", pulses, 0);

        // Table-driven fill: extend/clear priority, fill to capacity, overflow
        tbl[0] = '{1'b1, 1'b0, 1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 0, 1'b0};
        for (int i = 1; i <= 16; i++) tbl[i + 1] = '{1'b1, 1'b0, i, (i == 16)};
        tbl[18] = '{1'b1, 1'b0, 16, 1'b1};
        tbl[19] = '{1'b1, 1'b0, 16, 1'b1};
        for (int i = 0; i < 20; i++) begin
            if (tbl[i].c) do_clear();
            else if (tbl[i].e) do_ext();
            chk("tbl_length", length, tbl[i].exp_len);
            chk("tbl_full", full, tbl[i].exp_full);
        end

        // Full playback: 16 distinct prompt pulses
        run_play(1'b0, -1, 1'b1, pulses, to_done, fp);
        chk("full_pulses", pulses, 16);
        chk("full_done_at", to_done, 2 * 16 * dur(16));
`ifndef PROMPT_SPEEDUP_EN
        chk("full_done_128", to_done, 128);
`endif

        // Clear in the OFF phase of entry 2 of 3
        do_clear();
        repeat (3) do_ext();
        run_play(1'b0, 3 * dur(3) + 1, 1'b0, pulses, to_done, fp);
        chk("clr_never_done", to_done, -1);

        // Extend and play together with length 2; extends during busy ignored
        do_clear();
        repeat (2) do_ext();
        run_play(1'b1, -1, 1'b1, pulses, to_done, fp);
        chk("ext_play_pulses", pulses, 3);
        chk("ext_play_done_at", to_done, 6 * dur(3));
`ifndef PROMPT_SPEEDUP_EN
        chk("ext_play_done_24", to_done, 24);
`endif

        // Randomized sessions against the reference
        for (int it = 0; it < 8; it++) begin
            int n;
            if (($urandom % 4) == 0) do_clear();
            n = $urandom_range(0, 5);
            for (int j = 0; j < n; j++) do_ext();
            run_play(1'($urandom % 2), -1, 1'b1, pulses, to_done, fp);
            chk("rand_done_at", to_done, 2 * q.size() * dur(q.size()));
        end

        // Asynchronous reset in the middle of an ON phase
        do_clear();
        do_ext();
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("pre_rst_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_prompt", prompt, 0);
        chk("arst_busy", busy, 0);
        chk("arst_length", length, 0);
        chk("arst_done", done, 0);
        q.delete();
        @(negedge clock);
        reset = 1'b1;
        do_ext();
        run_play(1'b0, -1, 1'b0, pulses, to_done, fp);
        chk("post_rst_prompt", fp, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prompt_sequencer.md
Name: prompt_sequencer

Overview:
Upstream stage of the prompt display path. It generates and stores a pseudo-random sequence of prompt codes, adding one code per level, and plays the whole sequence back on request as timed prompt codes (1 toggle, 2 push, 3 mic, 4 mouse) for the LED driver. The game control FSM drives it with extend/play/clear pulses and uses its done pulse to move into user input.

Parameters:
MAX_LEN, 16, sequence capacity in entries (power of 2, 2..64)
TICK_DIV, 25000000, clock cycles per ON phase and per OFF phase (>=1)
LFSR_SEED, 8'hA5, LFSR reset value (must be nonzero)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; clears all state
extend  in  1  1-cycle pulse: append one random code
play  in  1  1-cycle pulse: start playback of the stored sequence
clear  in  1  synchronous: empty the sequence, abort playback
prompt  out  3  0 = blank, 1..4 = current prompt code
busy  out  1  high during ON/OFF playback phases
done  out  1  1-cycle pulse when playback completes
length  out  $clog2(MAX_LEN)+1  number of stored entries
full  out  1  length == MAX_LEN

Behaviour:
- Reset values: prompt=0, busy=0, done=0, length=0, full=0, LFSR=LFSR_SEED, FSM=IDLE, index=0, phase counter=0.
- LFSR: 8-bit Galois, right shift, feedback mask 8'hB8. It advances every clock, including during playback. It never reaches 0.
- Append: in IDLE, when extend=1 and full=0, the sequence stores {LFSR[1:0]} at address length. This uses the LFSR value before this edge's advance. length increments by 1. Stored code c plays back as c+1.
- extend is ignored while busy, in DONE, or when full. It is not queued.
- FSM states: IDLE, ON, OFF, DONE.
- IDLE -> ON on play=1 with length>0: index=0, counter=TICK_DIV-1.
- IDLE -> DONE on play=1 with length==0.
- ON: prompt=mem[index]+1, busy=1. Counter decrements each cycle. At 0, go to OFF with counter reloaded.
- OFF: prompt=0, busy=1. At counter 0: if index==length-1 go to DONE, else index+1 and go to ON with reload.
- DONE: done=1, busy=0, prompt=0 for exactly one cycle, then IDLE.
- Latency: prompt is nonzero in the cycle after the play edge. Total playback is 2*length*TICK_DIV cycles, followed by a 1-cycle done pulse.
- extend and play in the same IDLE cycle: both are accepted. The append happens at that edge and playback covers the new length.
- play while not IDLE is ignored.
- clear (any state) has priority over extend and play. Next cycle: length=0, FSM=IDLE, prompt=0, busy=0, no done pulse. The LFSR is unaffected.
- Asynchronous reset mid-playback returns all outputs to their reset values immediately.
- Counter width: $clog2(TICK_DIV)+1 bits. Phase length never truncates.

Optional Feature:
PROMPT_SPEEDUP_EN
- Defined: phase duration = max(TICK_DIV >> s, 1), where s = min(length>>2, 3). Prompts get faster every 4 levels, down to 1/8 speed duration. s is sampled when play is accepted and held for the whole playback.
- Undefined: phase duration is always TICK_DIV. No shifter logic is present.

Test Plan:
- Reset, then extend on the first active cycle (LFSR=8'hA5) -> length=1, stored code 01. Play with TICK_DIV=4 -> prompt=2 for 4 cycles, 0 for 4 cycles, then done=1 for 1 cycle, busy=0.
- Play with length=0 -> done pulses in the cycle after play, prompt stays 0, busy never high.
- Extend 16 times with MAX_LEN=16 -> full=1, length=16. A 17th extend -> length stays 16. Playback runs 128 cycles (TICK_DIV=4), showing exactly 16 nonzero prompt pulses, each value in 1..4.
- Assert clear during the OFF phase of entry 2 of 3 -> next cycle prompt=0, busy=0, length=0, and done never pulses.
- Extend and play in the same cycle with length=2 -> playback shows 3 prompts and done arrives after 24 cycles (TICK_DIV=4). Extend during busy -> length unchanged.
- With PROMPT_SPEEDUP_EN, TICK_DIV=8, length=8 -> each phase lasts 2 cycles and playback takes 32 cycles. Async reset mid-phase -> prompt=0 immediately.
